// File: rtl/gated_updown_counter.sv
// gated_updown_counter
//   Parametrised modulo up/down counter with synchronous load, a one-cycle
//   terminal-count (wrap) pulse and idle-driven clock gating of the count
//   register. The counter's outputs are cycle-identical with or without the
//   clock gate compiled in.
//
// Build option:
//   CNT_CLK_GATE_EN  defined   -> count register clocked through a latch-based
//                                 integrated clock gate (gclk = clk & latched_en)
//                    undefined -> count register on clk with a synchronous hold
//
// Parameters:
//   WIDTH        counter width in bits (>= 2)
//   MODULUS      count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   IDLE_CYCLES  consecutive idle cycles before the count clock is gated (>= 1)
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   en         in   count enable
//   dir        in   1 = count up, 0 = count down
//   load       in   synchronous load, has priority over en
//   load_val   in   load value (clamped to MODULUS-1)
//   count_out  out  current count
//   tc         out  wrap pulse, high with the first wrapped value
//   gated      out  1 while the count register clock is gated
module gated_updown_counter #(
    parameter int WIDTH       = 8,
    parameter int MODULUS     = 256,
    parameter int IDLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             gated
);

    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

    // MODULUS may equal 2**WIDTH, so the wrap compare needs one extra bit.
    localparam logic [WIDTH:0]    MOD_VAL   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]    MOD_MAX_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0]  MOD_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]    ONE_W     = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_GATED  = 1'b1;

    logic [WIDTH-1:0]  count_reg;
    logic [WIDTH-1:0]  count_next;
    logic [WIDTH:0]    count_inc;
    logic              wrap_next;
    logic              tc_reg;
    logic [0:0]        state_reg;
    logic [IDLE_W-1:0] idle_reg;
    logic              activity;
    logic              cnt_en;

    assign activity  = load | en;
    // Combinational wake: a request seen while gated opens the clock on the
    // very edge that samples it, so no operation is lost.
    assign cnt_en    = (state_reg == ST_ACTIVE) | activity;
    assign count_inc = {1'b0, count_reg} + ONE_W;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = ({1'b0, load_val} > MOD_MAX_W) ? MOD_MAX : load_val;
        end else if (en) begin
            if (dir) begin
                if (count_inc == MOD_VAL) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count_inc[WIDTH-1:0];
                end
            end else begin
                if (count_reg == '0) begin
                    count_next = MOD_MAX;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count_reg - ONE;
                end
            end
        end
    end

`ifdef CNT_CLK_GATE_EN
    // Enable latch is transparent while clk is low, so the enable is stable
    // for the whole high phase and gclk cannot glitch.
    logic en_latch;
    logic gclk;

    always_latch begin
        if (!clk) begin
            en_latch <= cnt_en;
        end
    end

    assign gclk = clk & en_latch;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (cnt_en) begin
            count_reg <= count_next;
        end
    end
`endif

    // Wrap pulse runs on the free clock; a wrap implies en, so the count
    // register is always enabled on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_reg <= 1'b0;
        end else begin
            tc_reg <= wrap_next;
        end
    end

    // Idle detector: IDLE_CYCLES consecutive idle edges move to GATED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ACTIVE;
            idle_reg  <= '0;
        end else begin
            case (state_reg)
                ST_ACTIVE: begin
                    if (activity) begin
                        idle_reg <= '0;
                    end else if (idle_reg == IDLE_LAST) begin
                        state_reg <= ST_GATED;
                        idle_reg  <= '0;
                    end else begin
                        idle_reg <= idle_reg + IDLE_ONE;
                    end
                end
                default: begin
                    if (activity) begin
                        state_reg <= ST_ACTIVE;
                    end
                end
            endcase
        end
    end

    assign count_out = count_reg;
    assign tc        = tc_reg;
    assign gated     = (state_reg == ST_GATED);

endmodule

// File: tb/tb_gated_updown_counter.sv
// tb_gated_updown_counter
//   Directed scenarios (reset, wraps, load clamp, gating, reset while gated,
//   load on wake) followed by a randomized stream, all compared against a
//   behavioural model kept in the bench.
module tb_gated_updown_counter;

    localparam int WIDTH       = 4;
    localparam int MODULUS     = 10;
    localparam int IDLE_CYCLES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             gated;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: count as an integer, gating derived from the length
    // of the current run of idle cycles.
    int m_count;
    int m_streak;
    bit m_tc;
    bit m_gated;

    gated_updown_counter #(
        .WIDTH      (WIDTH),
        .MODULUS    (MODULUS),
        .IDLE_CYCLES(IDLE_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .count_out(count_out),
        .tc       (tc),
        .gated    (gated)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_count  = 0;
        m_tc     = 1'b0;
        m_streak = 0;
        m_gated  = 1'b0;
    endtask

    // One clock: drive inputs on the falling edge, sample just after the
    // rising edge, advance the model.
    task automatic cycle(input bit l, input int v, input bit e, input bit d);
        @(negedge clk);
        load     = l;
        load_val = WIDTH'(v);
        en       = e;
        dir      = d;
        @(posedge clk);
        #1;
        if (l) begin
            m_count = (v > MODULUS - 1) ? MODULUS - 1 : v;
            m_tc    = 1'b0;
        end else if (e) begin
            if (d) begin
                m_tc    = (m_count == MODULUS - 1);
                m_count = (m_count + 1) % MODULUS;
            end else begin
                m_tc    = (m_count == 0);
                m_count = (m_count + MODULUS - 1) % MODULUS;
            end
        end else begin
            m_tc = 1'b0;
        end
        m_streak = (l || e) ? 0 : m_streak + 1;
        m_gated  = (m_streak >= IDLE_CYCLES);
        $display("txn load=%0b val=%0d en=%0b dir=%0b -> count=%0d tc=%0b gated=%0b",
                 l, v, e, d, count_out, tc, gated);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; dir = 1'b1; load = 1'b0; load_val = '0;
        model_reset();
        #22;
        checks++;
        if (count_out !== '0 || tc !== 1'b0 || gated !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs count=%0d tc=%0b gated=%0b required 0/0/0",
                     count_out, tc, gated);
        end
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_up_wrap();
        int exp_cnt[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 0, 1'b1, 1'b1);
            checks++;
            if (count_out !== WIDTH'(exp_cnt[i])) begin
                failures++;
                $display("FAIL up_wrap_count[%0d] got=%0d required=%0d", i, count_out, exp_cnt[i]);
            end
            checks++;
            if (tc !== (i == 9)) begin
                failures++;
                $display("FAIL up_wrap_tc[%0d] got=%0b required=%0b", i, tc, (i == 9));
            end
        end
    endtask

    task automatic test_down_wrap();
        int exp_cnt[3] = '{9, 8, 7};
        cycle(1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 0, 1'b1, 1'b0);
            checks++;
            if (count_out !== WIDTH'(exp_cnt[i]) || tc !== (i == 0)) begin
                failures++;
                $display("FAIL down_wrap[%0d] got=%0d/%0b required=%0d/%0b",
                         i, count_out, tc, exp_cnt[i], (i == 0));
            end
        end
    endtask

    task automatic test_load();
        cycle(1'b1, 7, 1'b1, 1'b1);
        checks++;
        if (count_out !== 4'd7 || tc !== 1'b0) begin
            failures++;
            $display("FAIL load_priority got=%0d/%0b required=7/0", count_out, tc);
        end
        cycle(1'b1, 12, 1'b0, 1'b1);
        checks++;
        if (count_out !== 4'd9) begin
            failures++;
            $display("FAIL load_clamp got=%0d required=9", count_out);
        end
        cycle(1'b0, 0, 1'b1, 1'b1);
        checks++;
        if (count_out !== 4'd0 || tc !== 1'b1) begin
            failures++;
            $display("FAIL load_then_wrap got=%0d/%0b required=0/1", count_out, tc);
        end
    endtask

    task automatic test_gating();
        cycle(1'b1, 5, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 0, 1'b0, 1'b0);
            checks++;
            if (gated !== (i >= 4) || count_out !== 4'd5) begin
                failures++;
                $display("FAIL gate_entry[%0d] gated=%0b count=%0d required=%0b/5",
                         i, gated, count_out, (i >= 4));
            end
        end
        cycle(1'b0, 0, 1'b1, 1'b1);
        checks++;
        if (count_out !== 4'd6 || gated !== 1'b0) begin
            failures++;
            $display("FAIL gate_wake got=%0d/%0b required=6/0", count_out, gated);
        end
        // A single active cycle restarts the idle run.
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 0, 1'b0, 1'b0);
            checks++;
            if (gated !== (i == 4) || count_out !== 4'd7) begin
                failures++;
                $display("FAIL gate_restart[%0d] gated=%0b count=%0d required=%0b/7",
                         i, gated, count_out, (i == 4));
            end
        end
    endtask

    task automatic test_reset_mid_gate();
        cycle(1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (gated !== 1'b1 || count_out !== 4'd3) begin
            failures++;
            $display("FAIL pre_reset_gated got=%0b/%0d required=1/3", gated, count_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count_out !== '0 || tc !== 1'b0 || gated !== 1'b0) begin
            failures++;
            $display("FAIL async_reset count=%0d tc=%0b gated=%0b required 0/0/0",
                     count_out, tc, gated);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset released");
        cycle(1'b0, 0, 1'b1, 1'b1);
        checks++;
        if (count_out !== 4'd1 || gated !== 1'b0) begin
            failures++;
            $display("FAIL resume_after_reset got=%0d/%0b required=1/0", count_out, gated);
        end
        // load and en together while gated: load completes on the wake edge.
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 4, 1'b1, 1'b1);
        checks++;
        if (count_out !== 4'd4 || tc !== 1'b0 || gated !== 1'b0) begin
            failures++;
            $display("FAIL load_on_wake got=%0d/%0b/%0b required=4/0/0", count_out, tc, gated);
        end
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 40; blk++) begin
            int p_en;
            p_en = int'($urandom_range(0, 3));
            for (int i = 0; i < 25; i++) begin
                bit l, e, d;
                int v;
                l = ($urandom_range(0, 15) == 0);
                e = (p_en == 0) ? ($urandom_range(0, 19) == 0) : (int'($urandom_range(0, 3)) < p_en);
                d = $urandom_range(0, 1) == 1;
                v = int'($urandom_range(0, 15));
                cycle(l, v, e, d);
                checks++;
                if (count_out !== WIDTH'(m_count) || tc !== m_tc || gated !== m_gated) begin
                    failures++;
                    $display("FAIL random[%0d] got=%0d/%0b/%0b required=%0d/%0b/%0b",
                             blk * 25 + i, count_out, tc, gated, m_count, m_tc, m_gated);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_gating();
        test_reset_mid_gate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
